// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : PC register, next-PC selection and synchronous imem addressing
//            for the fetch stage feeding decode/ALU; also latches jal link.
// Revision : 1.0  initial release
// ============================================================================
module instruction_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_ADDR_W = 14
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   Branch,
  input  logic                   nBranch,
  input  logic                   Jmp,
  input  logic                   Jal,
  input  logic                   Jr,
  input  logic                   Zero,
  input  logic [31:0]            Addr_Result,
  input  logic [31:0]            Read_data_1,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            Instruction,
  output logic [31:0]            branch_base_addr,
  output logic [31:0]            pc,
  output logic [31:0]            link_addr,
  output logic                   fetch_valid,
  output logic                   align_err
);

  typedef enum logic [0:0] {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_run;
  logic        w_advance;
  logic        w_branch_taken;
  logic        w_jr_misaligned;
  logic [31:0] r_pc;
  logic [31:0] r_link;
  logic        r_align_err;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_jump_target;
  logic [31:0] w_jr_target;
  logic [31:0] w_next_pc;

  // ---------------------------------------------------------------------------
  // Control FSM: BOOT covers the single cycle in which the RESET_PC word is
  // being read, so the first RUN cycle already has a valid Instruction.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    fetch_valid = 1'b0;
    case (r_state)
      S_BOOT: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_state_nxt = S_RUN;
        w_run       = 1'b1;
        fetch_valid = 1'b1;
      end
      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-PC selection
  // ---------------------------------------------------------------------------
  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_branch_taken  = (Branch & Zero) | (nBranch & ~Zero);
  assign w_jr_target     = {Read_data_1[31:2], 2'b00};
  assign w_jump_target   = {w_pc_plus4[31:28], imem_rdata[25:0], 2'b00};
  assign w_advance       = w_run & ~stall;
  assign w_jr_misaligned = Jr & (Read_data_1[1:0] != 2'b00);

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (Jr) begin
      w_next_pc = w_jr_target;
    end else if (Jmp | Jal) begin
      w_next_pc = w_jump_target;
    end else if (w_branch_taken) begin
      w_next_pc = Addr_Result;
    end
  end

  // ---------------------------------------------------------------------------
  // Architectural state. Stall freezes everything, link_addr included.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_link      <= 32'h0000_0000;
      r_align_err <= 1'b0;
    end else if (w_advance) begin
      r_pc <= w_next_pc;
      if (Jal) begin
        r_link <= w_pc_plus4;
      end
      if (w_jr_misaligned) begin
        r_align_err <= 1'b1;
      end
    end
  end

  // Address the word that will be current after the edge; this hides the
  // one-cycle memory read latency. Upper PC bits simply alias.
  always_comb begin
    imem_addr = RESET_PC[IMEM_ADDR_W+1:2];
    if (w_advance) begin
      imem_addr = w_next_pc[IMEM_ADDR_W+1:2];
    end else if (w_run) begin
      imem_addr = r_pc[IMEM_ADDR_W+1:2];
    end
  end

  assign Instruction      = imem_rdata;
  assign branch_base_addr = w_pc_plus4;
  assign pc               = r_pc;
  assign link_addr        = r_link;
  assign align_err        = r_align_err;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch
// Purpose  : Directed self-checking bench for instruction_fetch with a
//            spec-level reference model and per-cycle comparison.
// Revision : 1.0  initial release
// ============================================================================
module tb_instruction_fetch;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
  localparam int          C_AW       = 14;

  logic            clock;
  logic            reset;
  logic            stall;
  logic            Branch;
  logic            nBranch;
  logic            Jmp;
  logic            Jal;
  logic            Jr;
  logic            Zero;
  logic [31:0]     Addr_Result;
  logic [31:0]     Read_data_1;
  logic [C_AW-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic [31:0]     Instruction;
  logic [31:0]     branch_base_addr;
  logic [31:0]     pc;
  logic [31:0]     link_addr;
  logic            fetch_valid;
  logic            align_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:(1<<C_AW)-1];

  instruction_fetch #(
    .RESET_PC    (C_RESET_PC),
    .IMEM_ADDR_W (C_AW)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .stall            (stall),
    .Branch           (Branch),
    .nBranch          (nBranch),
    .Jmp              (Jmp),
    .Jal              (Jal),
    .Jr               (Jr),
    .Zero             (Zero),
    .Addr_Result      (Addr_Result),
    .Read_data_1      (Read_data_1),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .Instruction      (Instruction),
    .branch_base_addr (branch_base_addr),
    .pc               (pc),
    .link_addr        (link_addr),
    .fetch_valid      (fetch_valid),
    .align_err        (align_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Synchronous-read instruction memory
  always @(posedge clock) imem_rdata <= mem[imem_addr];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_run;
  logic [31:0] m_pc;
  logic [31:0] m_link;
  logic        m_align;

  function automatic logic [31:0] model_next(input logic [31:0] cur);
    logic [31:0] seq;
    logic [31:0] word;
    seq  = cur + 32'd4;
    word = mem[cur[C_AW+1:2]];
    if (Jr)                                   return {Read_data_1[31:2], 2'b00};
    if (Jmp || Jal)                           return {seq[31:28], word[25:0], 2'b00};
    if ((Branch && Zero) || (nBranch && !Zero)) return Addr_Result;
    return seq;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_run   <= 1'b0;
      m_pc    <= C_RESET_PC;
      m_link  <= 32'h0;
      m_align <= 1'b0;
    end else if (!m_run) begin
      m_run <= 1'b1;
    end else if (!stall) begin
      m_pc <= model_next(m_pc);
      if (Jal) m_link <= m_pc + 32'd4;
      if (Jr && Read_data_1[1:0] != 2'b00) m_align <= 1'b1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    logic [31:0] exp_fetch;
    exp_fetch = (m_run && !stall) ? model_next(m_pc) : m_pc;
    if (!m_run) exp_fetch = C_RESET_PC;
    chk("cyc_pc", pc, m_pc);
    chk("cyc_bba", branch_base_addr, m_pc + 32'd4);
    chk("cyc_valid", {31'b0, fetch_valid}, {31'b0, m_run});
    chk("cyc_link", link_addr, m_link);
    chk("cyc_align", {31'b0, align_err}, {31'b0, m_align});
    chk("cyc_imem_addr", {18'b0, imem_addr}, {18'b0, exp_fetch[C_AW+1:2]});
    if (m_run) chk("cyc_instr", Instruction, mem[m_pc[C_AW+1:2]]);
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic jr_to(input logic [31:0] tgt);
    Jr = 1'b1; Read_data_1 = tgt;
    step(1);
    Jr = 1'b0; Read_data_1 = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < (1 << C_AW); i++)
      mem[i] = 32'h2000_0000 | ((i * 32'h35 + 32'h11) & 32'h03FF_FFFF);
    mem[8] = 32'h0C00_0100;

    reset = 1'b1; stall = 1'b0; Branch = 1'b0; nBranch = 1'b0; Jmp = 1'b0;
    Jal = 1'b0; Jr = 1'b0; Zero = 1'b0; Addr_Result = 32'h0; Read_data_1 = 32'h0;
    step(2);
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'b0, fetch_valid}, 32'h0);
    chk("rst_link", link_addr, 32'h0);
    chk("rst_align", {31'b0, align_err}, 32'h0);

    reset = 1'b0;
    chk("boot_valid", {31'b0, fetch_valid}, 32'h0);
    chk("boot_imem_addr", {18'b0, imem_addr}, 32'h0);
    step(1);
    chk("run_valid", {31'b0, fetch_valid}, 32'h1);
    chk("run_pc0", pc, 32'h0);
    chk("run_bba", branch_base_addr, 32'h4);
    step(1); chk("seq_pc4", pc, 32'h4);
    step(1); chk("seq_pc8", pc, 32'h8);
    step(1); chk("seq_pcC", pc, 32'hC);
    step(1); chk("seq_pc10", pc, 32'h10);

    Branch = 1'b1; Zero = 1'b1; Addr_Result = 32'h40;
    step(1);
    Branch = 1'b0; Zero = 1'b0;
    chk("beq_taken", pc, 32'h40);
    chk("model_beq", m_pc, 32'h40);

    jr_to(32'h10);
    Branch = 1'b1; Zero = 1'b0;
    step(1);
    Branch = 1'b0;
    chk("beq_not_taken", pc, 32'h14);

    jr_to(32'h10);
    nBranch = 1'b1; Zero = 1'b0;
    step(1);
    nBranch = 1'b0;
    chk("bne_taken", pc, 32'h40);

    jr_to(32'h20);
    chk("jal_instr", Instruction, 32'h0C00_0100);
    Jal = 1'b1;
    step(1);
    Jal = 1'b0;
    chk("jal_pc", pc, 32'h400);
    chk("jal_link", link_addr, 32'h24);
    chk("model_link", m_link, 32'h24);

    Jal = 1'b1; Jr = 1'b1; Read_data_1 = 32'h20;
    step(1);
    Jal = 1'b0; Jr = 1'b0; Read_data_1 = 32'h0;
    chk("jaljr_pc", pc, 32'h20);
    chk("jaljr_link", link_addr, 32'h404);

    stall = 1'b1; Jal = 1'b1;
    step(2);
    chk("stall_pc", pc, 32'h20);
    chk("stall_link", link_addr, 32'h404);
    chk("stall_instr", Instruction, 32'h0C00_0100);
    stall = 1'b0; Jal = 1'b0;

    Jr = 1'b1; Jmp = 1'b1; Read_data_1 = 32'h83;
    step(1);
    Jr = 1'b0; Jmp = 1'b0; Read_data_1 = 32'h0;
    chk("jr_pc", pc, 32'h80);
    chk("jr_align", {31'b0, align_err}, 32'h1);
    step(10);
    chk("align_sticky", {31'b0, align_err}, 32'h1);

    jr_to(32'hFFFF_FFFC);
    chk("wrap_pre_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pre_bba", branch_base_addr, 32'h0);
    step(1);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_bba", branch_base_addr, 32'h4);

    Jmp = 1'b1;
    step(2);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("midrst_pc", pc, C_RESET_PC);
    chk("midrst_valid", {31'b0, fetch_valid}, 32'h0);
    chk("midrst_link", link_addr, 32'h0);
    chk("midrst_align", {31'b0, align_err}, 32'h0);
    @(posedge clock);
    #1 reset = 1'b0;
    chk("reboot_valid", {31'b0, fetch_valid}, 32'h0);
    chk("reboot_imem_addr", {18'b0, imem_addr}, 32'h0);
    step(1);
    Jmp = 1'b0;
    chk("rerun_valid", {31'b0, fetch_valid}, 32'h1);
    chk("rerun_pc0", pc, 32'h0);
    step(1); chk("rerun_pc4", pc, 32'h4);
    step(1); chk("rerun_pc8", pc, 32'h8);

    @(posedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
